// File: rtl/xor_sched_pkg.sv
// Shared definitions for the round-robin XOR scheduler: state encoding,
// default sizes and a constant-foldable clog2.
package xor_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  localparam int DEF_N = 4;
  localparam int DEF_W = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/xor_rr_sched_rr_pick.sv
// Combinational round-robin pick: rotate req so ptr lands on bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  localparam int SUM_W = IW + 1;

  logic [N-1:0]     rot;
  logic [IW-1:0]    off;
  logic [SUM_W-1:0] sum;

  always_comb begin
    // Doubling req makes the right shift behave as a rotate for any N.
    rot   = N'({req, req} >> ptr);
    found = |req;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = IW'(i);
    end
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= SUM_W'(N)) sum = sum - SUM_W'(N);
    idx = IW'(sum);
  end

endmodule

// File: rtl/xor_rr_sched.sv
// Shares one registered XOR unit among N requesters with round-robin
// arbitration; each operation takes a grant cycle and a result cycle.
module xor_rr_sched
  import xor_sched_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int W  = DEF_W,
  parameter int IW = clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_flat,
  input  logic [N*W-1:0] b_flat,
  output logic [N-1:0]   gnt,
  output logic           busy,
  output logic           res_valid,
  output logic [IW-1:0]  res_id,
  output logic [W-1:0]   res_data
);

  state_e        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win_q, win_d;
  logic [W-1:0]  op_a_q, op_a_d;
  logic [W-1:0]  op_b_q, op_b_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          res_valid_q, res_valid_d;
  logic [IW-1:0] res_id_q, res_id_d;
  logic [W-1:0]  res_data_q, res_data_d;

  logic          pick_found;
  logic [IW-1:0] pick_idx;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    gnt_d       = '0;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_d[pick_idx] = 1'b1;
          state_d         = ST_EXEC;
          busy_d          = 1'b1;
          win_d           = pick_idx;
          op_a_d          = a_flat[pick_idx*W +: W];
          op_b_d          = b_flat[pick_idx*W +: W];
          if (pick_idx == IW'(N - 1)) ptr_d = '0;
          else                        ptr_d = pick_idx + IW'(1);
        end
      end
      ST_EXEC: begin
        // req is deliberately not looked at here; a held request is
        // re-arbitrated once back in IDLE.
        res_data_d  = op_a_q ^ op_b_q;
        res_id_d    = win_q;
        res_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_xor_rr_sched.sv
// Directed bench for xor_rr_sched with N=4, W=8 and hand-computed results.
module tb_xor_rr_sched;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_flat;
  logic [N*W-1:0] b_flat;
  logic [N-1:0]   gnt;
  logic           busy;
  logic           res_valid;
  logic [IW-1:0]  res_id;
  logic [W-1:0]   res_data;

  int n_checks = 0;
  int n_errors = 0;

  xor_rr_sched #(.N(N), .W(W), .IW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a_flat    (a_flat),
    .b_flat    (b_flat),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_flat[i*W +: W] = a;
    b_flat[i*W +: W] = b;
  endtask

  logic [W-1:0] all_res [4] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
  logic [N-1:0] all_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    a_flat = '0;
    b_flat = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {gnt, busy, res_valid, res_id, res_data}, 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("idle_outputs_c%0d", c), {gnt, busy, res_valid, res_id, res_data}, 32'h0);
    end

    // Single requester: index 2, A5 ^ 0F = AA.
    set_ops(2, 8'hA5, 8'h0F);
    req = 4'b0100;
    tick();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_busy", busy, 1);
    chk("single_no_valid_yet", res_valid, 0);
    req = '0;
    tick();
    chk("single_valid", res_valid, 1);
    chk("single_id", res_id, 2);
    chk("single_data", res_data, 8'hAA);
    chk("single_gnt_clear", gnt, 0);
    chk("single_busy_clear", busy, 0);
    tick();
    chk("hold_valid_pulse", res_valid, 0);
    chk("hold_data", res_data, 8'hAA);
    chk("hold_id", res_id, 2);

    // Wrap and skip: ptr is 3 now, req 0011 -> index 0 then index 1.
    set_ops(0, 8'h3C, 8'hC3);
    set_ops(1, 8'h12, 8'h34);
    req = 4'b0011;
    tick();
    chk("wrap_gnt0", gnt, 4'b0001);
    req = 4'b0010;
    tick();
    chk("wrap_res0_valid", res_valid, 1);
    chk("wrap_res0_id", res_id, 0);
    chk("wrap_res0_data", res_data, 8'hFF);
    tick();
    chk("wrap_gnt1", gnt, 4'b0010);
    req = '0;
    tick();
    chk("wrap_res1_id", res_id, 1);
    chk("wrap_res1_data", res_data, 8'h26);

    // Withdrawn request: req[1] only visible while index 0 is in EXEC.
    set_ops(0, 8'h0F, 8'h01);
    req = 4'b0001;
    tick();
    chk("wd_gnt0", gnt, 4'b0001);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    tick();
    chk("wd_res0_valid", res_valid, 1);
    chk("wd_res0_data", res_data, 8'h0E);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("wd_no_gnt_c%0d", c), gnt, 0);
      chk($sformatf("wd_not_busy_c%0d", c), busy, 0);
    end

    // Reset mid-EXEC: the in-flight operation must vanish.
    set_ops(2, 8'hA5, 8'h0F);
    req = 4'b0100;
    tick();
    chk("rst_mid_gnt", gnt, 4'b0100);
    req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_async", {gnt, busy, res_valid, res_id, res_data}, {4'b0, 1'b0, 1'b0, 2'd1, 8'h26} & 32'h0);
    tick();
    chk("rst_mid_held_valid", res_valid, 0);
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk($sformatf("rst_mid_no_valid_c%0d", c), res_valid, 0);
    end
    set_ops(3, 8'h55, 8'hF0);
    req = 4'b1000;
    tick();
    chk("rst_after_gnt3", gnt, 4'b1000);
    req = '0;
    tick();
    chk("rst_after_valid", res_valid, 1);
    chk("rst_after_id", res_id, 3);
    chk("rst_after_data", res_data, 8'hA5);

    // All requesters held: grants 0,1,2,3,0 two cycles apart.
    for (int i = 0; i < N; i++) set_ops(i, W'(i), 8'hFF);
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick();
      chk($sformatf("all_gnt_%0d", g), gnt, all_gnt[g]);
      chk($sformatf("all_busy_%0d", g), busy, 1);
      if (g < 4) begin
        tick();
        chk($sformatf("all_gap_%0d", g), gnt, 0);
        chk($sformatf("all_valid_%0d", g), res_valid, 1);
        chk($sformatf("all_id_%0d", g), res_id, g);
        chk($sformatf("all_data_%0d", g), res_data, all_res[g]);
      end
    end
    req = '0;
    tick();
    chk("all_last_id", res_id, 0);
    chk("all_last_data", res_data, 8'hFF);
    tick();
    chk("all_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xor_rr_sched.md
# xor_rr_sched

Round-robin scheduler that shares one registered XOR datapath among N requesters. Each requester presents an operand pair and a request. The scheduler grants one requester at a time, latches its operands, and computes `a ^ b` in a register stage. It returns the result tagged with the requester index. It sits between the stimulus/requester logic and the single XOR unit, and removes the need for one XOR register per client.

## Interface
Parameters:
- `N`, default 4: number of requesters, 2..16.
- `W`, default 8: operand and result width.
- `IW`, default 2: index width, equal to clog2(N).

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: reset, asynchronous assert, active-low.
- `req`, in, N: per-requester request level.
- `a_flat`, in, N*W: operand A; requester i occupies bits `[i*W +: W]`.
- `b_flat`, in, N*W: operand B; same packing as `a_flat`.
- `gnt`, out, N: one-hot grant pulse, registered.
- `busy`, out, 1: high while an operation is in flight.
- `res_valid`, out, 1: one-cycle result strobe.
- `res_id`, out, IW: index of the requester that owns the result.
- `res_data`, out, W: XOR result.

## Operation
FSM with two states, IDLE and EXEC.

- **Reset.** When `rst_n` is low, the following values apply immediately, independent of `clk`:
  - state = IDLE
  - round-robin pointer `ptr` = 0
  - `gnt` = 0, `busy` = 0, `res_valid` = 0, `res_id` = 0, `res_data` = 0
  - operand latches cleared
- **IDLE, `req` == 0.** Stay in IDLE. All strobes are 0.
- **IDLE, `req` != 0.**
  - Winner is the first set bit of `req`, scanning from `ptr` upward and wrapping from N-1 to 0.
  - On the next edge: `gnt[winner]` = 1, state = EXEC, `busy` = 1.
  - The winner's operands are latched from `a_flat`/`b_flat` at that same edge.
  - `ptr` is set to (winner+1) mod N.
- **EXEC.**
  - `gnt` returns to 0.
  - `req` is ignored.
  - On the next edge: `res_data` = latched a ^ latched b, `res_id` = winner, `res_valid` = 1, `busy` = 0, state = IDLE.
- **Requester obligations.**
  - Hold `req` and the operands stable until `gnt` is observed.
  - Drop `req` in the cycle `gnt` is high, unless another operation is wanted.
  - If `req` is still high when the FSM returns to IDLE, it is arbitrated as a new request.
- **Withdrawn request.** A request withdrawn before a grant is simply never granted. There is no error.
- **Output hold.** `res_data` and `res_id` hold their last values after `res_valid` falls. Only `res_valid` is a pulse.
- **Width rule.** `res_data` is exactly W bits, with no carry or extension.

## Timing
- `req` sampled high at edge k:
  - `gnt` high during cycle k+1
  - `res_valid` high during cycle k+2
- Latency from request sample to result is 2 cycles.
- Peak throughput is one operation per 2 cycles. The first IDLE sample can coincide with the `res_valid` cycle, so back-to-back grants occur every 2 cycles.
- `gnt`, `res_valid`, and `busy` are all register outputs. There are no combinational paths from inputs to outputs.
- **Fairness.** With all N requesting continuously, each requester is granted exactly once in every 2N cycles.
- **Wrap-around.** A grant to index N-1 sets `ptr` to 0.
- **Mid-operation reset.** If `rst_n` falls while in EXEC:
  - the in-flight result is discarded and `res_valid` is never asserted for it;
  - after release, `ptr` = 0.
- **Release from reset.** `rst_n` is released synchronously by the upstream reset synchronizer. The first arbitration happens at the first rising edge after release.

## Structure
- Shared package/header `xor_sched_pkg`:
  - state encodings `ST_IDLE` = 1'b0, `ST_EXEC` = 1'b1;
  - the default values for `N` and `W`;
  - a clog2 function.
- Sub-module `rr_pick`:
  - purely combinational;
  - inputs `req[N]` and `ptr[IW]`;
  - outputs `found` and `idx[IW]`;
  - implemented as a rotate, then a priority encode, then an un-rotate;
  - reusable by later arbiters.
- Top level contains the FSM, `ptr`, the operand latches, and the XOR register.

## Test plan
- **Reset values.** Apply reset, then release with no requests for 10 cycles. Required: all outputs stay 0, `busy` = 0.
- **Single requester.** N=4, W=8. `req` = 4'b0100, A[2] = 8'hA5, B[2] = 8'h0F. Required:
  - `gnt` = 4'b0100 one cycle later;
  - next cycle `res_valid` = 1, `res_id` = 2, `res_data` = 8'hAA.
- **All requesters held continuously.** `req` = 4'b1111, A[i] = i, B[i] = 8'hFF. Required:
  - grant order 0, 1, 2, 3, 0, with grants 2 cycles apart;
  - results FF, FE, FD, FC.
- **Wrap and skip.** Set `ptr` = 3 via a prior grant to index 2. Then `req` = 4'b0011. Required: grants go to index 0, then to index 1.
- **Reset mid-EXEC.** Assert `rst_n` = 0 during the EXEC cycle. Required:
  - `res_valid` never pulses for that operation;
  - after release, `req` = 4'b1000 yields `res_id` = 3.
- **Withdrawn request.** `req[1]` is asserted while index 0 is in EXEC, then dropped before the return to IDLE. Required: no grant for index 1, and `busy` = 0 afterwards.
